// File: rtl/mult_ctrl_if.sv
// Bundle between the execute stage, mult_ctrl and the attached signed multiplier.
// slave is the mult_ctrl side; master is the execute stage plus multiplier side.
interface mult_ctrl_if;
  logic        start;
  logic        madd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_lo;
  logic [31:0] mul_hi;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic        rd_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport slave (
    input  start, madd, op_a, op_b, mul_lo, mul_hi, mthi_we, mtlo_we, wdata, rd_req,
    output mul_a, mul_b, hi, lo, busy, done, stall
  );

  modport master (
    output start, madd, op_a, op_b, mul_lo, mul_hi, mthi_we, mtlo_we, wdata, rd_req,
    input  mul_a, mul_b, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_ctrl.sv
// HI/LO control stage in front of a fixed-latency signed 32x32 multiplier.
// Holds operands for MULT_LATENCY edges, then overwrites or accumulates {hi,lo}.
module mult_ctrl #(
  parameter int MULT_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_ctrl_if.slave  bus
);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] sum;

  assign sum = {hi_q, lo_q} + {bus.mul_hi, bus.mul_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      RUN: begin
        // start/MTHI/MTLO are dropped here; operands stay frozen for the multiplier
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (acc_q) {hi_d, lo_d} = sum;
          else       {hi_d, lo_d} = {bus.mul_hi, bus.mul_lo};
          state_d = DONE;
        end
      end
      default: begin
        if (bus.mthi_we) hi_d = bus.wdata;
        if (bus.mtlo_we) lo_d = bus.wdata;
        if (bus.start) begin
          mul_a_d = bus.op_a;
          mul_b_d = bus.op_b;
          acc_d   = bus.madd;
          cnt_d   = CNT_W'(MULT_LATENCY - 1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.stall = bus.rd_req & bus.busy;
endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: latency-32 instance with a pipelined multiplier model,
// plus a latency-1 instance for the back-to-back corner.
module tb_mult_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  mult_ctrl_if u_if0 ();
  mult_ctrl_if u_if1 ();

  mult_ctrl #(.MULT_LATENCY(32)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
  mult_ctrl #(.MULT_LATENCY(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

  // Multiplier model: product valid 31 edges after launch, sampled on the 32nd.
  logic signed [63:0] ea0, eb0, ea1, eb1;
  logic [63:0] prod0, prod1;
  logic [63:0] pipe0 [0:30];
  assign ea0 = {{32{u_if0.mul_a[31]}}, u_if0.mul_a};
  assign eb0 = {{32{u_if0.mul_b[31]}}, u_if0.mul_b};
  assign prod0 = ea0 * eb0;
  always @(posedge clk) begin
    for (int i = 30; i > 0; i--) pipe0[i] <= pipe0[i-1];
    pipe0[0] <= prod0;
  end
  assign {u_if0.mul_hi, u_if0.mul_lo} = pipe0[30];

  assign ea1 = {{32{u_if1.mul_a[31]}}, u_if1.mul_a};
  assign eb1 = {{32{u_if1.mul_b[31]}}, u_if1.mul_b};
  assign prod1 = ea1 * eb1;
  assign {u_if1.mul_hi, u_if1.mul_lo} = prod1;

  typedef struct {
    string       nm;
    logic        madd;
    logic        pre_we;
    logic        same;
    logic [31:0] hi0, lo0, a, b;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    if (v.pre_we) begin
      u_if0.wdata = v.hi0; u_if0.mthi_we = 1'b1;
      @(negedge clk);
      u_if0.mthi_we = 1'b0; u_if0.wdata = v.lo0; u_if0.mtlo_we = 1'b1;
      if (!v.same) begin
        @(negedge clk);
        u_if0.mtlo_we = 1'b0;
      end
    end
    u_if0.start = 1'b1; u_if0.madd = v.madd; u_if0.op_a = v.a; u_if0.op_b = v.b;
    @(negedge clk);
    u_if0.start = 1'b0; u_if0.mtlo_we = 1'b0;
    chk({v.nm, "_busy"}, 64'(u_if0.busy), 64'd1);
    chk({v.nm, "_opab"}, {u_if0.mul_a, u_if0.mul_b}, {v.a, v.b});
    cyc = 1;
    @(negedge clk);
    while (u_if0.busy && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    chk({v.nm, "_lat"}, 64'(cyc), 64'd32);
    chk({v.nm, "_done"}, 64'(u_if0.done), 64'd1);
    chk({v.nm, "_hilo"}, {u_if0.hi, u_if0.lo}, v.exp);
    @(negedge clk);
    chk({v.nm, "_done_off"}, 64'(u_if0.done), 64'd0);
  endtask

  task automatic wait_idle0(input string nm);
    int cyc;
    cyc = 0;
    while (u_if0.busy && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 64'(u_if0.busy), 64'd0);
  endtask

  initial begin
    vt[0] = '{"neg",     1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA};
    vt[1] = '{"acc",     1'b1, 1'b1, 1'b0, 32'h0,        32'h10,       32'd5,        32'd7,        64'h00000000_00000033};
    vt[2] = '{"acc_same",1'b1, 1'b1, 1'b1, 32'h0,        32'h10,       32'd5,        32'd7,        64'h00000000_00000033};
    vt[3] = '{"wrap",    1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd1,        64'h0};
    vt[4] = '{"carry",   1'b1, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd1,        32'd1,        64'h00000001_00000000};
    vt[5] = '{"maxpos",  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    vt[6] = '{"minneg",  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vt[7] = '{"borrow",  1'b1, 1'b1, 1'b0, 32'h1,        32'h0,        32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF};

    u_if0.start = 0; u_if0.madd = 0; u_if0.op_a = 0; u_if0.op_b = 0;
    u_if0.mthi_we = 0; u_if0.mtlo_we = 0; u_if0.wdata = 0; u_if0.rd_req = 0;
    u_if1.start = 0; u_if1.madd = 0; u_if1.op_a = 0; u_if1.op_b = 0;
    u_if1.mthi_we = 0; u_if1.mtlo_we = 0; u_if1.wdata = 0; u_if1.rd_req = 0;

    repeat (2) @(negedge clk);
    chk("rst_hilo", {u_if0.hi, u_if0.lo}, 64'h0);
    chk("rst_opab", {u_if0.mul_a, u_if0.mul_b}, 64'h0);
    chk("rst_flags", {61'h0, u_if0.busy, u_if0.done, u_if0.stall}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Reset mid-RUN discards the in-flight result
    u_if0.start = 1'b1; u_if0.madd = 1'b0; u_if0.op_a = 32'd7; u_if0.op_b = 32'd9;
    @(negedge clk);
    u_if0.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_flags", {62'h0, u_if0.busy, u_if0.done}, 64'h0);
    chk("mrst_hilo", {u_if0.hi, u_if0.lo}, 64'h0);
    chk("mrst_opab", {u_if0.mul_a, u_if0.mul_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mrst_after", {u_if0.hi, u_if0.lo}, 64'h0);
    chk("mrst_busy", 64'(u_if0.busy), 64'd0);

    // Events during RUN are ignored; rd_req stalls
    u_if0.rd_req = 1'b1;
    #1 chk("stall_idle", 64'(u_if0.stall), 64'd0);
    u_if0.rd_req = 1'b0;
    u_if0.start = 1'b1; u_if0.op_a = 32'd3; u_if0.op_b = 32'd5;
    @(negedge clk);
    u_if0.start = 1'b0;
    repeat (4) @(negedge clk);
    u_if0.start = 1'b1; u_if0.op_a = 32'd100; u_if0.op_b = 32'd100;
    u_if0.mthi_we = 1'b1; u_if0.wdata = 32'hDEAD; u_if0.rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_stall", 64'(u_if0.stall), 64'd1);
      chk("run_opab", {u_if0.mul_a, u_if0.mul_b}, {32'd3, 32'd5});
      chk("run_hi", 64'(u_if0.hi), 64'h0);
    end
    u_if0.start = 1'b0; u_if0.mthi_we = 1'b0;
    wait_idle0("ign");
    chk("ign_done", 64'(u_if0.done), 64'd1);
    chk("ign_stall_done", 64'(u_if0.stall), 64'd0);
    chk("ign_hilo", {u_if0.hi, u_if0.lo}, 64'd15);
    u_if0.rd_req = 1'b0;
    @(negedge clk);
    chk("ign_no_requeue", 64'(u_if0.busy), 64'd0);

    // Back-to-back at latency 32: second start in the DONE cycle
    u_if0.start = 1'b1; u_if0.op_a = 32'd3; u_if0.op_b = 32'd4;
    @(negedge clk);
    u_if0.start = 1'b0;
    wait_idle0("b2b0");
    chk("b2b0_first", {u_if0.hi, u_if0.lo}, 64'd12);
    chk("b2b0_done1", 64'(u_if0.done), 64'd1);
    u_if0.start = 1'b1; u_if0.op_a = 32'd6; u_if0.op_b = 32'hFFFFFFFF;
    @(negedge clk);
    u_if0.start = 1'b0;
    chk("b2b0_nogap", 64'(u_if0.busy), 64'd1);
    wait_idle0("b2b0b");
    chk("b2b0_final", {u_if0.hi, u_if0.lo}, 64'hFFFFFFFF_FFFFFFFA);

    // Same sequence at latency 1
    u_if1.start = 1'b1; u_if1.op_a = 32'd3; u_if1.op_b = 32'd4;
    @(negedge clk);
    u_if1.start = 1'b0;
    chk("b2b1_busy", {62'h0, u_if1.busy, u_if1.done}, 64'b10);
    @(negedge clk);
    chk("b2b1_done", {62'h0, u_if1.busy, u_if1.done}, 64'b01);
    chk("b2b1_first", {u_if1.hi, u_if1.lo}, 64'd12);
    u_if1.start = 1'b1; u_if1.op_a = 32'd6; u_if1.op_b = 32'hFFFFFFFF;
    @(negedge clk);
    u_if1.start = 1'b0;
    chk("b2b1_nogap", {62'h0, u_if1.busy, u_if1.done}, 64'b10);
    @(negedge clk);
    chk("b2b1_done2", {62'h0, u_if1.busy, u_if1.done}, 64'b01);
    chk("b2b1_final", {u_if1.hi, u_if1.lo}, 64'hFFFFFFFF_FFFFFFFA);
    @(negedge clk);
    chk("b2b1_idle", {62'h0, u_if1.busy, u_if1.done}, 64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequential control stage sitting directly upstream of the signed 32x32 `mult` unit. It accepts a multiply or multiply-accumulate request from the execute stage and holds the operands stable on the multiplier inputs for a fixed latency. It then captures the 64-bit `{higher, lower}` product into architectural HI/LO registers (overwrite or accumulate). HI/LO are also directly writable (MTHI/MTLO), and the block produces a stall when HI/LO are read mid-operation.

## Interface
- `MULT_LATENCY`, 32: clock edges from operand launch until `mul_hi`/`mul_lo` are valid; legal range 1..255. Must match the attached multiplier.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE/DONE.
- `madd`  in  1  qualifies `start`: 1 = accumulate into HI/LO, 0 = overwrite.
- `op_a`, `op_b`  in  32  signed operands, sampled with `start`.
- `mul_a`, `mul_b`  out  32  registered operands driven to the multiplier `a`/`b`.
- `mul_lo`, `mul_hi`  in  32  multiplier `lower`/`higher` outputs.
- `mthi_we`, `mtlo_we`  in  1  direct HI/LO write enables.
- `wdata`  in  32  data for MTHI/MTLO.
- `rd_req`  in  1  execute stage wants to read HI or LO this cycle.
- `hi`, `lo`  out  32  architectural HI/LO.
- `busy`  out  1  operation in flight (state RUN).
- `done`  out  1  one-cycle pulse, HI/LO were just updated by a multiply.
- `stall`  out  1  combinational `rd_req & busy`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - latch `op_a`/`op_b` into `mul_a`/`mul_b`.
  - latch `madd` into `acc_mode`.
  - load `cnt` = MULT_LATENCY-1.
  - go to RUN.
- IDLE/DONE with `start`=0: DONE goes to IDLE; IDLE stays.
- RUN with `cnt`≠0: decrement `cnt`.
- RUN with `cnt`=0, on the next edge:
  - `acc_mode`=0: `{hi,lo}` ← `{mul_hi,mul_lo}`.
  - `acc_mode`=1: `{hi,lo}` ← `{hi,lo}` + `{mul_hi,mul_lo}`, 64-bit add modulo 2^64, carry from lo into hi, no saturation.
  - go to DONE.
- `done` = 1 exactly while in DONE. `busy` = 1 exactly while in RUN.
- `mul_a`/`mul_b` hold their value from launch until the next accepted `start`; never change during RUN.
- MTHI/MTLO:
  - applied on the clock edge only in IDLE/DONE; ignored (dropped) in RUN.
  - same edge as an accepted `start`: the write is applied. A later MADD accumulates onto HI/LO as they stand at the capture edge, i.e. including that write.
- `start` in RUN is ignored, with no queueing; upstream must hold it while `busy`.
- `rd_req` in RUN asserts `stall`. Read data is valid once `busy` falls (DONE cycle onward).

## Timing
- Reset (`rst_n`=0, async, at any time including mid-RUN) forces:
  - state=IDLE, `cnt`=0.
  - `mul_a`=`mul_b`=0, `hi`=`lo`=0.
  - `busy`=`done`=0; `stall`=0 unless `rd_req`&`busy`.
  - An in-flight result is discarded.
- Start accepted at edge E0: `busy` high from E0 to E0+MULT_LATENCY, i.e. MULT_LATENCY cycles.
- HI/LO update at edge E0+MULT_LATENCY. `done` high for the following cycle.
- MULT_LATENCY=1: RUN lasts one cycle; capture at E0+1.
- Back-to-back: `start` in the DONE cycle is accepted. Issue-to-issue throughput is MULT_LATENCY+1 cycles.

## Test plan
- Reset mid-RUN: start `op_a`=7 `op_b`=9, assert `rst_n`=0 after 10 cycles → `busy`/`done` drop immediately, `hi`=`lo`=0. The result never lands even after `rst_n` releases.
- Basic multiply with a real `mult` attached: `op_a`=-2, `op_b`=3, `madd`=0 → `busy` high exactly 32 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, one-cycle `done`.
- Accumulate: MTHI 0, MTLO 0x10, then MADD 5×7 → `hi`=0, `lo`=0x33.
- Carry/wrap: `hi`=`lo`=0xFFFFFFFF, MADD 1×1 → `hi`=0, `lo`=0. Also MADD 1×1 on `hi`=0, `lo`=0xFFFFFFFF → `hi`=1, `lo`=0.
- Ignored events in RUN: assert `start` (op 100×100), `mthi_we` (wdata 0xDEAD), and `rd_req` during RUN → `stall`=1 each cycle with `rd_req`, operands unchanged, `hi` not 0xDEAD. Final result matches the first operation only.
- Back-to-back: 3×4 then `start` 6×(-1) in the DONE cycle → second op accepted with no idle gap; final `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Sequence repeated with MULT_LATENCY=1 passes.
